// File: rtl/ring_counter_pkg.sv
// rtl/ring_counter_pkg.sv - shared constants and one-hot helpers for ring_counter
package ring_counter_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_INIT_POS   = 0;
    localparam int DEF_SHIFT_LEFT = 1;
    localparam int MAX_WIDTH      = 32;

    // One-hot vector with bit idx set; out-of-range indices give all zeros.
    function automatic logic [MAX_WIDTH-1:0] onehot_of(input int unsigned idx,
                                                       input int unsigned width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        if ((idx < width) && (idx < MAX_WIDTH)) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

    // True when exactly one bit of vec is set.
    function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            cnt = cnt + int'(vec[i]);
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/ring_counter_onehot_check.sv
// rtl/ring_counter_onehot_check.sv - combinational zero / multiple-hot detector
module onehot_check
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] vec,
    output logic             is_zero,
    output logic             is_multi
);

    logic seen;

    // Walk the bits; a set bit after one has already been seen means multiple-hot
    always_comb begin
        seen     = 1'b0;
        is_multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            is_multi = is_multi | (seen & vec[i]);
            seen     = seen | vec[i];
        end
    end

    assign is_zero = ~|vec;

endmodule

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - self-correcting one-hot ring counter with position, wrap and error flags
module ring_counter
    import ring_counter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int INIT_POS   = DEF_INIT_POS,
    parameter int SHIFT_LEFT = DEF_SHIFT_LEFT
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     wrap,
    output logic                     err
);

    localparam int PW = $clog2(WIDTH);

    localparam logic [MAX_WIDTH-1:0] INIT_VEC = onehot_of(INIT_POS, WIDTH);
    localparam logic [WIDTH-1:0]     INIT_Q   = INIT_VEC[WIDTH-1:0];
    localparam logic [PW-1:0]        INIT_P   = PW'(INIT_POS);
    localparam logic [PW-1:0]        LAST_P   = PW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] rot_q;
    logic [PW-1:0]    rot_pos;
    logic             zero_hot;
    logic             multi_hot;

    onehot_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .vec      (q_q),
        .is_zero  (zero_hot),
        .is_multi (multi_hot)
    );

    // Rotation target and matching position step for the configured direction
    generate
        if (SHIFT_LEFT != 0) begin : g_left
            assign rot_q   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            assign rot_pos = (pos_q == LAST_P) ? '0 : pos_q + 1'b1;
        end else begin : g_right
            assign rot_q   = {q_q[0], q_q[WIDTH-1:1]};
            assign rot_pos = (pos_q == '0) ? LAST_P : pos_q - 1'b1;
        end
    endgenerate

    // Next state: rotate when legal, otherwise snap back to the start slot and latch the error
    always_comb begin
        q_d    = rot_q;
        pos_d  = rot_pos;
        wrap_d = 1'b0;
        err_d  = err_q;
        if (zero_hot || multi_hot) begin
            q_d   = INIT_Q;
            pos_d = INIT_P;
            err_d = 1'b1;
        end else begin
            // A rotation of a one-hot value lands on INIT_Q only from the adjacent slot
            wrap_d = (rot_q == INIT_Q);
        end
    end

    // State registers; reset wins over rotation and correction
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= INIT_Q;
            pos_q  <= INIT_P;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = q_q;
    assign pos  = pos_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ring_counter.sv
// tb/tb_ring_counter.sv - directed self-checking bench for ring_counter
module tb_ring_counter;

    logic       clk;
    logic       reset;
    logic [3:0] q;
    logic [1:0] pos;
    logic       wrap;
    logic       err;
    logic [7:0] q8;
    logic [2:0] pos8;
    logic       wrap8;
    logic       err8;

    int vectors;
    int miscompares;

    ring_counter dut (
        .clk   (clk),
        .reset (reset),
        .q     (q),
        .pos   (pos),
        .wrap  (wrap),
        .err   (err)
    );

    ring_counter #(
        .WIDTH      (8),
        .INIT_POS   (3),
        .SHIFT_LEFT (0)
    ) dut8 (
        .clk   (clk),
        .reset (reset),
        .q     (q8),
        .pos   (pos8),
        .wrap  (wrap8),
        .err   (err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_q [5];
        logic [1:0] exp_p [5];
        logic       exp_w [5];
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_p = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            vectors++;
            if (q !== exp_q[i] || pos !== exp_p[i] || wrap !== exp_w[i] || err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_seq[%0d]: q=%b pos=%0d wrap=%b err=%b, expected q=%b pos=%0d wrap=%b err=0",
                         i, q, pos, wrap, err, exp_q[i], exp_p[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_long_run();
        logic [3:0] eq;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            tick();
            eq = 4'b0001 << (k % 4);
            vectors++;
            if (q !== eq || pos !== 2'(k % 4) || wrap !== (k % 4 == 0) || err !== 1'b0) begin
                miscompares++;
                $display("FAIL long_run[%0d]: q=%b pos=%0d wrap=%b err=%b, expected q=%b pos=%0d wrap=%b err=0",
                         k, q, pos, wrap, err, eq, k % 4, (k % 4 == 0));
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        tick();
        tick();
        vectors++;
        if (q !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_reset_pre: q=%b expected 0100", q);
        end
        do_reset();
        vectors++;
        if (q !== 4'b0001 || pos !== 2'd0 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_at_0100: q=%b pos=%0d wrap=%b, expected q=0001 pos=0 wrap=0", q, pos, wrap);
        end
        tick();
        vectors++;
        if (q !== 4'b0010 || pos !== 2'd1) begin
            miscompares++;
            $display("FAIL mid_reset_restart: q=%b pos=%0d, expected q=0010 pos=1", q, pos);
        end
        tick();
        tick();
        do_reset();
        vectors++;
        if (q !== 4'b0001 || pos !== 2'd0 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_at_1000: q=%b pos=%0d wrap=%b, expected q=0001 pos=0 wrap=0", q, pos, wrap);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] exp_q [4];
        logic       exp_w [4];
        exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_w = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        tick();
        force dut.q_q = 4'b0110;
        #1;
        release dut.q_q;
        vectors++;
        if (q !== 4'b0110) begin
            miscompares++;
            $display("FAIL illegal_forced: q=%b expected 0110", q);
        end
        tick();
        vectors++;
        if (q !== 4'b0001 || pos !== 2'd0 || err !== 1'b1 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_multi_fix: q=%b pos=%0d err=%b wrap=%b, expected q=0001 pos=0 err=1 wrap=0",
                     q, pos, err, wrap);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (q !== exp_q[i] || wrap !== exp_w[i] || err !== 1'b1) begin
                miscompares++;
                $display("FAIL illegal_resume[%0d]: q=%b wrap=%b err=%b, expected q=%b wrap=%b err=1",
                         i, q, wrap, err, exp_q[i], exp_w[i]);
            end
        end
        force dut.q_q = 4'b0000;
        #1;
        release dut.q_q;
        tick();
        vectors++;
        if (q !== 4'b0001 || pos !== 2'd0 || err !== 1'b1 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_zero_fix: q=%b pos=%0d err=%b wrap=%b, expected q=0001 pos=0 err=1 wrap=0",
                     q, pos, err, wrap);
        end
        do_reset();
        vectors++;
        if (err !== 1'b0 || q !== 4'b0001) begin
            miscompares++;
            $display("FAIL illegal_err_clear: err=%b q=%b, expected err=0 q=0001", err, q);
        end
    endtask

    task automatic test_variant();
        logic [7:0] exp_q [9];
        logic [2:0] exp_p [9];
        exp_q = '{8'b00001000, 8'b00000100, 8'b00000010, 8'b00000001, 8'b10000000,
                  8'b01000000, 8'b00100000, 8'b00010000, 8'b00001000};
        exp_p = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            vectors++;
            if (q8 !== exp_q[i] || pos8 !== exp_p[i] || wrap8 !== (i == 8) || err8 !== 1'b0) begin
                miscompares++;
                $display("FAIL variant8[%0d]: q=%b pos=%0d wrap=%b err=%b, expected q=%b pos=%0d wrap=%b err=0",
                         i, q8, pos8, wrap8, err8, exp_q[i], exp_p[i], (i == 8));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        test_reset();
        test_long_run();
        test_mid_reset();
        test_illegal();
        test_variant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
